// File: rtl/two_output_demux.sv
// two_output_demux: steers one valid/ready stream into output A (s=1) or
// output B (s=0). Each output owns a 2-entry in-order buffer and a wrapping
// count of beats delivered downstream.
module two_output_demux #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  input  logic                 s,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     a_data,
  output logic                 a_valid,
  input  logic                 a_ready,
  output logic [WIDTH-1:0]     b_data,
  output logic                 b_valid,
  input  logic                 b_ready,
  output logic [CNT_WIDTH-1:0] a_count,
  output logic [CNT_WIDTH-1:0] b_count
);

  // Index 0 is output A, index 1 is output B throughout.
  logic [WIDTH-1:0]     head_q [2];
  logic [WIDTH-1:0]     head_d [2];
  logic [WIDTH-1:0]     tail_q [2];
  logic [WIDTH-1:0]     tail_d [2];
  logic [1:0]           occ_q  [2];
  logic [1:0]           occ_d  [2];
  logic [CNT_WIDTH-1:0] cnt_q  [2];
  logic [CNT_WIDTH-1:0] cnt_d  [2];
  logic                 push   [2];
  logic                 pop    [2];
  logic                 accept;

  // Readiness only looks at the selected buffer's registered occupancy, so
  // there is no combinational path from either downstream ready to in_ready.
  assign in_ready = s ? (occ_q[0] != 2'd2) : (occ_q[1] != 2'd2);
  assign accept   = in_valid & in_ready;

  assign push[0] = accept & s;
  assign push[1] = accept & ~s;
  assign pop[0]  = (occ_q[0] != 2'd0) & a_ready;
  assign pop[1]  = (occ_q[1] != 2'd0) & b_ready;

  assign a_data  = head_q[0];
  assign a_valid = (occ_q[0] != 2'd0);
  assign a_count = cnt_q[0];
  assign b_data  = head_q[1];
  assign b_valid = (occ_q[1] != 2'd0);
  assign b_count = cnt_q[1];

  // Next-state of each buffer; the head only changes when a new beat becomes
  // the head, so an emptied buffer keeps showing its last popped value.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      head_d[i] = head_q[i];
      tail_d[i] = tail_q[i];
      occ_d[i]  = occ_q[i];
      cnt_d[i]  = cnt_q[i];
      if (pop[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
      end
      case (occ_q[i])
        2'd0: begin
          if (push[i]) begin
            head_d[i] = in_data;
            occ_d[i]  = 2'd1;
          end
        end
        2'd1: begin
          if (push[i] && pop[i]) begin
            head_d[i] = in_data;
          end else if (push[i]) begin
            tail_d[i] = in_data;
            occ_d[i]  = 2'd2;
          end else if (pop[i]) begin
            occ_d[i]  = 2'd0;
          end
        end
        2'd2: begin
          if (pop[i]) begin
            head_d[i] = tail_q[i];
            if (push[i]) begin
              tail_d[i] = in_data;
            end else begin
              occ_d[i] = 2'd1;
            end
          end
        end
        default: begin
          occ_d[i] = 2'd0;
        end
      endcase
    end
  end

  // Register both buffers and counters; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        head_q[i] <= '0;
        tail_q[i] <= '0;
        occ_q[i]  <= 2'd0;
        cnt_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        head_q[i] <= head_d[i];
        tail_q[i] <= tail_d[i];
        occ_q[i]  <= occ_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

endmodule

// File: doc/two_output_demux.md
# two_output_demux

Routes a single WIDTH-bit valid/ready input stream to one of two output streams, A or B, chosen per transfer by select `s`. It is the receiving-end counterpart of `two_input_mux` and uses the same select polarity: `s`=1 selects A, `s`=0 selects B. Each output has a 2-entry buffer, so one output can stall without losing data or throughput on the other output. Per-output transfer counters support bench and debug visibility.

## Interface
- `WIDTH`, default 32: data width of the input and both outputs.
- `CNT_WIDTH`, default 16: width of each transfer counter.

Ports:
- `clk` input 1: single clock. All state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `in_data` input WIDTH: input payload.
- `in_valid` input 1: input payload is valid.
- `s` input 1: destination of the current input beat. 1 = A, 0 = B. Sampled only on an accepted beat.
- `in_ready` output 1: the demux can accept a beat for destination `s`.
- `a_data` output WIDTH: head of buffer A.
- `a_valid` output 1: buffer A is non-empty.
- `a_ready` input 1: downstream consumer of A accepts the head.
- `b_data`, `b_valid`, `b_ready`: same as the A ports, for output B.
- `a_count` output CNT_WIDTH: number of beats popped from A.
- `b_count` output CNT_WIDTH: number of beats popped from B.

## Operation
- Push: an input beat is accepted when `in_valid` & `in_ready`. The beat is written to buffer A if `s`=1, otherwise to buffer B. Nothing is written to the unselected buffer.
- `in_ready`: combinational, equal to (occupancy of the selected buffer < 2). It depends only on `s` and registered occupancy, never on `a_ready` or `b_ready`.
- Pop: an output beat is transferred when `x_valid` & `x_ready`. The head entry is removed and `x_count` increments by 1.
- Buffers: each is a 2-entry FIFO with occupancy 0, 1 or 2 and strict in-order delivery.
  - `x_valid` = (occupancy ≠ 0).
  - `x_data` = head entry, registered.
  - `x_data` is 0 when the buffer has been empty since reset. Otherwise it holds the last popped value while empty.
- Occupancy transitions per cycle for each buffer:
  - Push only: +1.
  - Pop only: −1.
  - Push and pop together: unchanged.
- Simultaneous push and pop at occupancy 1: the head becomes the pushed beat on the next cycle.
- Push into a full buffer is impossible, because `in_ready` is 0.
- A and B are fully independent. A push to one buffer and a pop from the other can occur in the same cycle.
- Counters wrap modulo 2^CNT_WIDTH (0xFFFF → 0x0000). Counters never saturate.
- No other state exists. There is no state machine beyond the occupancy of each buffer.

## Timing
- Reset values, on the first edge with `reset`=1:
  - `a_valid` = `b_valid` = 0.
  - `a_data` = `b_data` = 0.
  - `a_count` = `b_count` = 0.
  - Both occupancies = 0.
  - Consequently `in_ready` = 1.
- Reset mid-operation: all buffered beats are discarded and counters are cleared. Handshakes on the reset cycle have no effect.
- Latency: a beat accepted at edge N into an empty buffer is presented as `x_valid`=1 with its data in the cycle after edge N. A beat accepted behind an existing entry appears when that entry pops.
- Throughput: 1 beat/cycle per output while its consumer keeps `x_ready`=1.
- Backpressure: with `x_ready`=0, buffer X fills after 2 accepted beats. `in_ready` then reads 0 whenever `s` selects X, and still reads 1 for the other output if that buffer is not full.
- Stability rule for the upstream side: `in_valid`, `in_data` and `s` must be held stable while `in_valid`=1 and `in_ready`=0.
- Output-side guarantee: `x_data` is stable while `x_valid`=1 and `x_ready`=0.

## Test plan
- Reset then idle:
  - Assert `reset` for 2 cycles.
  - Required: both valids 0, both data 0, both counts 0, `in_ready`=1.
- Routing, with both readys held at 1:
  - Push 0xAAAAAAAA with `s`=1, then 0xCCCCCCCC with `s`=0.
  - Required: `a_data`=0xAAAAAAAA with `a_valid`=1 one cycle after acceptance, while `b_valid` stays 0.
  - Required next cycle: `b_data`=0xCCCCCCCC with `b_valid`=1.
  - Required at the end: `a_count`=1, `b_count`=1.
- Backpressure on A only:
  - Hold `a_ready`=0 and push 0x1, 0x2, 0x3 with `s`=1.
  - Required: `in_ready` drops to 0 after 2 accepts, while `s`=0 still shows `in_ready`=1.
  - Then release `a_ready`.
  - Required: A delivers 0x1, 0x2, 0x3 in order, and `a_count`=3.
- Push and pop together at occupancy 1:
  - Fill A with 0x10, then push 0x20 in the same cycle that 0x10 pops.
  - Required: next cycle `a_data`=0x20, `a_valid`=1, occupancy 1.
- Reset mid-operation:
  - With 2 beats in B and `b_count`=5, assert `reset` for one cycle.
  - Required: `b_valid`=0, `b_count`=0, `in_ready`=1.
  - Required: subsequent beats route normally.
- Counter wrap:
  - Pop 65536 beats through A.
  - Required: `a_count` returns to 0x0000, and `b_count` is unaffected.
